imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write side of the instruction-memory interface. The RISC_V core only reads instruction memory.
//  This block accepts program words over a valid/ready stream and writes them sequentially into
//  instruction memory. It holds the core in reset while loading and releases it once the load completes.
//  It sits between the boot/debug stream source and the instruction memory write port, and drives the core's rst_n.
// PARAMETERS
//  DATA_W     32      instruction word width
//  ADDR_W     8       word-index width; DEPTH = 2**ADDR_W words
//  BASE_ADDR  32'h0   byte address of word 0 on imem_addr
// PORTS
//  clk          in   1         single clock, rising edge
//  rst_n        in   1         reset: asynchronous, active-low
//  start        in   1         request a load; sampled only in IDLE
//  word_count   in   ADDR_W+1  words to load; latched when start is accepted
//  abort        in   1         cancel an in-progress load
//  s_valid      in   1         stream word valid
//  s_data       in   DATA_W    stream word
//  s_ready      out  1         loader can take a word
//  imem_we      out  1         instruction-memory write enable
//  imem_addr    out  32        byte address, word aligned
//  imem_wdata   out  DATA_W    write data
//  core_rst_n   out  1         active-low reset to core; 0 = core held
//  busy         out  1         load in progress
//  done         out  1         one-cycle pulse: load complete
//  err          out  1         sticky error flag
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; idx=0.
//   - imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
//   - core_rst_n=0, busy=0, done=0, err=0.
//  FSM states: IDLE, LOAD, FINISH.
//   IDLE, start=1, 1<=word_count<=DEPTH:
//    - latch count; idx=0; err=0.
//    - core_rst_n=0 and busy=1 from the next cycle; go to LOAD.
//   IDLE, start=1, word_count==0 or >DEPTH:
//    - err=1 next cycle; stay IDLE; core_rst_n unchanged.
//   LOAD:
//    - s_ready=1 (decoded from the state register).
//    - A transfer occurs when s_valid&s_ready. Next cycle: imem_we=1,
//      imem_addr=BASE_ADDR+{idx,2'b00}, imem_wdata=s_data, and idx increments. Write latency is 1.
//    - No transfer: imem_we=0 next cycle.
//    - A transfer with idx==count-1 goes to FINISH.
//   FINISH (one cycle):
//    - The last word's imem_we is high in this cycle.
//    - done=1 and busy=0 next cycle; core_rst_n=1 next cycle; go to IDLE.
//   abort=1 in LOAD:
//    - abort beats a simultaneous transfer; that word is not written.
//    - go to IDLE; err=1; core_rst_n stays 0; imem_we=0 next cycle.
//    - abort in IDLE or FINISH has no effect.
//   start outside IDLE is ignored. s_valid outside LOAD is ignored (s_ready=0).
//  Width and address rules:
//   - idx never exceeds count-1, so imem_addr never wraps.
//   - count=DEPTH writes the full memory.
//  core_rst_n stays 0 from reset until the first successful load completes.
//  Reset asserted mid-load: all state clears per the reset values; partial memory contents are left as-is.
// STRUCTURE
//  - Shared riscv_defs package/header holds XLEN=32 and the loader state encodings
//    (IDLE=2'd0, LOAD=2'd1, FINISH=2'd2).
//  - Single module, no sub-modules; the word counter and write register are inline.
//  - In the top level, core rst_n is the logical AND of the board rst_n and core_rst_n.
// TESTING
//  1. Reset, no start: core_rst_n=0, s_ready=0, imem_we=0 indefinitely.
//  2. start, word_count=3; words 0x00500113, 0x00C00193, 0x002081B3 with s_valid held high:
//     - imem_we on 3 consecutive cycles at addr 0x0/0x4/0x8 with those data.
//     - done pulses once; core_rst_n=1 one cycle after FINISH.
//  3. Same load with s_valid toggling 1,0,0,1,0,1: writes occur only on the cycle after each valid beat;
//     addresses are 0x0/0x4/0x8 with no gaps or repeats.
//  4. start with word_count=0, then with word_count=DEPTH+1: err=1, state stays IDLE, s_ready=0, no writes.
//  5. word_count=4; abort asserted on the same cycle as the 3rd transfer:
//     - only 2 writes occur; err=1; core_rst_n=0.
//     - a following valid start clears err.
//  6. rst_n pulsed low during LOAD after 2 writes: outputs take reset values immediately (asynchronously);
//     a fresh load of DEPTH words then writes 0x0 through 4*(DEPTH-1) and releases the core.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: core word width,
// loader FSM state encodings and the word-index to byte-address helper.
package imem_loader_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FINISH = 2'd2
    } loader_state_e;

    // Word index to word-aligned byte address, offset from the memory base.
    function automatic logic [XLEN-1:0] word_byte_addr(
        input logic [XLEN-1:0] base,
        input logic [XLEN-1:0] idx
    );
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Valid/ready program-word stream between the boot/debug source and the loader.
interface imem_loader_if #(
    parameter int DATA_W = 32
);

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes program words off a valid/ready stream,
// writes them to consecutive word addresses of instruction memory, and holds
// the core in reset until a complete load has landed.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 8,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    imem_loader_if.slave      stream,
    output logic              imem_we,
    output logic [XLEN-1:0]   imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    loader_state_e     state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              core_q, core_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              load_active;
    logic              xfer;
    logic              count_ok;
    logic [CNT_W-1:0]  last_idx;

    assign load_active    = (state_q == ST_LOAD);
    assign stream.s_ready = load_active;
    assign xfer           = stream.s_valid & load_active;
    assign count_ok       = (word_count != '0) && (word_count <= DEPTH_CNT);
    assign last_idx       = count_q - CNT_W'(1);

    // Registers all FSM state and the write/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            core_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            core_q  <= core_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; abort takes priority over a same-cycle transfer.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        core_d  = core_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count_ok) begin
                        count_d = word_count;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        core_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (abort) begin
                    err_d   = 1'b1;
                    core_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    we_d    = 1'b1;
                    addr_d  = word_byte_addr(BASE_ADDR, XLEN'(idx_q));
                    wdata_d = stream.s_data;
                    idx_d   = idx_q + CNT_W'(1);
                    if (idx_q == last_idx) begin
                        state_d = ST_FINISH;
                    end
                end
            end

            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                core_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst_n = rst_n & core_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal loads, stalled stream, bad counts,
// abort mid-load, and asynchronous reset followed by a full-depth load.
module tb_imem_loader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic              imem_we;
    logic [31:0]       imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader_if #(.DATA_W(DATA_W)) stream ();

    imem_loader #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .abort      (abort),
        .stream     (stream.slave),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_seen = 0;
    int          done_cyc = -1;
    int          core_up_cyc = -1;
    logic        core_prev = 1'b0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic [31:0] words[DEPTH];

    // Cycle counter used to time-stamp observed events.
    always @(posedge clk) cyc <= cyc + 1;

    // Logs every memory write, done pulse and core-release edge.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_seen = done_seen + 1;
            done_cyc  = cyc;
        end
        if (core_rst_n === 1'b1 && core_prev !== 1'b1) core_up_cyc = cyc;
        core_prev = core_rst_n;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [ADDR_W:0] wc, input logic ab,
                                 input logic v, input logic [31:0] d);
        @(posedge clk);
        #2;
        start          = st;
        word_count     = wc;
        abort          = ab;
        stream.s_valid = v;
        stream.s_data  = d;
    endtask

    task automatic clearLog();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_seen   = 0;
        done_cyc    = -1;
        core_up_cyc = -1;
    endtask

    task automatic startLoad(input logic [ADDR_W:0] wc);
        applyStimulus(1'b1, wc, 1'b0, 1'b0, 32'h0);
    endtask

    // Presents n words; pat gives the valid pattern for the first patlen cycles, then valid stays high.
    task automatic sendWords(input int n, input logic [31:0] pat, input int patlen);
        int   sent;
        int   c;
        logic v;
        sent = 0;
        c    = 0;
        while (sent < n && c < 4 * n + 64) begin
            v = (c < patlen) ? pat[c] : 1'b1;
            applyStimulus(1'b0, '0, 1'b0, v, v ? words[sent] : 32'hDEAD_BEEF);
            if (v) sent = sent + 1;
            c = c + 1;
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic waitDone(input string tag);
        int k;
        k = 0;
        while (done_seen == 0 && k < 20) begin
            @(negedge clk);
            k = k + 1;
        end
        repeat (2) @(negedge clk);
        checkOutput({tag, "_done_pulses"}, done_seen, 1);
    endtask

    task automatic checkWrites(input string tag, input int n);
        checkOutput({tag, "_nwrites"}, wr_addr.size(), n);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), wr_addr[i], 32'(4 * i));
            checkOutput($sformatf("%s_data%0d", tag, i), wr_data[i], words[i]);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        stream.s_valid = 1'b0;
        stream.s_data  = '0;
        words[0] = 32'h0050_0113;
        words[1] = 32'h00C0_0193;
        words[2] = 32'h0020_81B3;
        words[3] = 32'h0000_0013;

        // Reset values while rst_n is held low.
        #12;
        checkOutput("rst_we",     imem_we,    1'b0);
        checkOutput("rst_addr",   imem_addr,  32'h0);
        checkOutput("rst_wdata",  imem_wdata, 32'h0);
        checkOutput("rst_core",   core_rst_n, 1'b0);
        checkOutput("rst_busy",   busy,       1'b0);
        checkOutput("rst_done",   done,       1'b0);
        checkOutput("rst_err",    err,        1'b0);
        checkOutput("rst_sready", stream.s_ready, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Idle with no start: stream beats are ignored and the core stays held.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, '0, 1'b0, i[0], 32'h1234_0000 + 32'(i));
            @(negedge clk);
            checkOutput($sformatf("idle_core%0d", i),   core_rst_n,     1'b0);
            checkOutput($sformatf("idle_sready%0d", i), stream.s_ready, 1'b0);
            checkOutput($sformatf("idle_we%0d", i),     imem_we,        1'b0);
        end
        checkOutput("idle_nwrites", wr_addr.size(), 0);

        // Three-word load with valid held high.
        clearLog();
        startLoad(9'd3);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t2_busy",   busy,           1'b1);
        checkOutput("t2_sready", stream.s_ready, 1'b1);
        checkOutput("t2_core",   core_rst_n,     1'b0);
        sendWords(3, 32'hFFFF_FFFF, 0);
        waitDone("t2");
        checkWrites("t2", 3);
        if (wr_cyc.size() == 3) begin
            checkOutput("t2_gap01", wr_cyc[1] - wr_cyc[0], 1);
            checkOutput("t2_gap12", wr_cyc[2] - wr_cyc[1], 1);
            checkOutput("t2_done_lat", done_cyc - wr_cyc[2], 1);
        end
        checkOutput("t2_core_up_at_done", core_up_cyc, done_cyc);
        checkOutput("t2_core_end", core_rst_n, 1'b1);
        checkOutput("t2_busy_end", busy,       1'b0);
        checkOutput("t2_err_end",  err,        1'b0);

        // Same load with valid pattern 1,0,0,1,0,1.
        clearLog();
        startLoad(9'd3);
        sendWords(3, 32'h0000_0029, 6);
        waitDone("t3");
        checkWrites("t3", 3);
        if (wr_cyc.size() == 3) begin
            checkOutput("t3_gap01", wr_cyc[1] - wr_cyc[0], 3);
            checkOutput("t3_gap12", wr_cyc[2] - wr_cyc[1], 2);
        end
        checkOutput("t3_core_end", core_rst_n, 1'b1);

        // Oversized count: error flag, stays idle, core left released.
        clearLog();
        startLoad(9'(DEPTH + 1));
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hBAD0_0001);
        @(negedge clk);
        checkOutput("t4a_err",    err,            1'b1);
        checkOutput("t4a_sready", stream.s_ready, 1'b0);
        checkOutput("t4a_busy",   busy,           1'b0);
        checkOutput("t4a_core",   core_rst_n,     1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t4a_nwrites", wr_addr.size(), 0);

        // Four-word load aborted on the third transfer.
        clearLog();
        startLoad(9'd4);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, words[0]);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, words[1]);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, words[2]);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        checkWrites("t5", 2);
        checkOutput("t5_err",    err,            1'b1);
        checkOutput("t5_core",   core_rst_n,     1'b0);
        checkOutput("t5_busy",   busy,           1'b0);
        checkOutput("t5_sready", stream.s_ready, 1'b0);
        checkOutput("t5_done",   done_seen,      0);

        // A valid start afterwards clears the error and completes.
        clearLog();
        startLoad(9'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t5_err_cleared", err,  1'b0);
        checkOutput("t5_busy_again",  busy, 1'b1);
        sendWords(1, 32'hFFFF_FFFF, 0);
        waitDone("t5r");
        checkWrites("t5r", 1);
        checkOutput("t5r_core", core_rst_n, 1'b1);

        // Zero count: error flag, stays idle, no writes.
        clearLog();
        startLoad(9'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hBAD0_0002);
        @(negedge clk);
        checkOutput("t4b_err",    err,            1'b1);
        checkOutput("t4b_sready", stream.s_ready, 1'b0);
        checkOutput("t4b_busy",   busy,           1'b0);
        checkOutput("t4b_core",   core_rst_n,     1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t4b_nwrites", wr_addr.size(), 0);

        // Asynchronous reset in the middle of a load after two writes.
        clearLog();
        startLoad(9'd4);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, words[0]);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, words[1]);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h0);
        checkOutput("t6_pre_addr", imem_addr, 32'h4);
        checkOutput("t6_pre_busy", busy,      1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_we",     imem_we,        1'b0);
        checkOutput("t6_rst_addr",   imem_addr,      32'h0);
        checkOutput("t6_rst_wdata",  imem_wdata,     32'h0);
        checkOutput("t6_rst_core",   core_rst_n,     1'b0);
        checkOutput("t6_rst_busy",   busy,           1'b0);
        checkOutput("t6_rst_sready", stream.s_ready, 1'b0);
        checkOutput("t6_nwrites_before", wr_addr.size(), 2);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Full-depth load after the reset.
        for (int i = 0; i < DEPTH; i++) words[i] = 32'h1000_0000 + 32'(i);
        clearLog();
        startLoad(9'(DEPTH));
        sendWords(DEPTH, 32'hFFFF_FFFF, 0);
        waitDone("t6");
        checkWrites("t6", DEPTH);
        checkOutput("t6_core", core_rst_n, 1'b1);
        checkOutput("t6_err",  err,        1'b0);
        checkOutput("t6_busy", busy,       1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
